// File: rtl/my_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package my_adder_pkg;

    // Default operand width for the serial arithmetic blocks.
    localparam int MY_ADDER_DEFAULT_WIDTH = 8;

    // Control FSM states shared by the serial arithmetic blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_e;

    // Signed overflow of x+y given the operand and result sign bits.
    function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic s_msb);
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

endpackage

// File: rtl/my_full_adder.sv
// Full adder built from two half adders plus an OR of their carries.
// Latency: combinational.
// Backpressure: none.
module my_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s0;
    logic c0;
    logic c1;

    my_half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    my_half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign carry = c0 | c1;

endmodule

// File: rtl/my_half_adder.sv
// Half adder cell: sum = a ^ b, carry = a & b.
// Latency: combinational.
// Backpressure: none.
module my_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/my_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first through one full adder; optional signed
// overflow output with MY_SERIAL_ADDER_OVERFLOW_EN. Latency: result valid WIDTH
// cycles after accept. Backpressure: DONE holds outputs until out_ready.
module my_serial_adder
    import my_adder_pkg::*;
#(
    parameter int WIDTH = MY_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    adder_state_e     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_carry;
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // The single full-adder cell consumes the operand LSBs and the running carry.
    my_full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next-state logic: accept in IDLE, one bit per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_carry;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
                    // carry_q is the carry into the MSB on this last bit.
                    ovf_d = carry_q ^ fa_carry;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_q;
`ifdef MY_SERIAL_ADDER_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: doc/my_serial_adder.md
# my_serial_adder

Bit-serial N-bit adder that accepts two operands over a valid/ready handshake. It adds them LSB-first, one bit per clock, through a single full-adder cell, then returns the sum and carry-out over a second valid/ready handshake. It sits directly downstream of the half-adder cell: two half adders form the full adder, and this block wraps that full adder with a carry register, shift registers and control.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: operands `a`/`b` valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: operand A, unsigned, or two's complement with overflow option.
- `b`  in  WIDTH: operand B.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `sum`  out  WIDTH: a + b modulo 2^WIDTH.
- `carry_out`  out  1: carry out of the MSB.
- `overflow`  out  1: signed overflow; present only with `MY_SERIAL_ADDER_OVERFLOW_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b` into shift registers, clear carry register, clear bit counter, go to RUN.
- RUN:
  - Each cycle, the full adder takes the shift-register LSBs plus the carry register.
  - The sum bit shifts into the MSB of the sum shift register; the carry register takes the full-adder carry.
  - Operand registers shift right by one; the counter increments.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - `out_valid`=1; `sum`, `carry_out` and `overflow` held stable.
  - On `out_valid && out_ready`: go to IDLE.
- `in_ready` is 1 only in IDLE. There is no accept in DONE, even when the result is consumed in the same cycle.
- `in_valid` while not ready is ignored; inputs are sampled only at handshake.
- Arithmetic:
  - `sum` = (a+b) mod 2^WIDTH.
  - `carry_out` = bit WIDTH of a+b.
  - `overflow` = carry into MSB XOR carry out of MSB.
- Counter width is clog2(WIDTH+1); no wrap occurs within an operation.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, `in_ready`=1 after the edge, `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0, carry register=0, counter=0.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result discarded; outputs take their reset values next cycle.
- Latency: handshake at edge T → RUN for edges T+1..T+WIDTH → `out_valid`=1 after edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH run cycles, one DONE cycle with `out_ready`=1).
- Backpressure: DONE holds indefinitely while `out_ready`=0; outputs must not change.
- `out_ready` asserted before `out_valid` has no effect.
- Outputs are registered; no combinational path from inputs to outputs except none (`in_ready` derives from state only).

## Configuration
- Macro: `MY_SERIAL_ADDER_OVERFLOW_EN`.
- Defined: the `overflow` port exists. The block registers the carry into the MSB during the final RUN cycle and drives `overflow` in DONE as defined above.
- Undefined: no `overflow` port and no extra register; all other behaviour is identical.

## Structure
- Package `my_adder_pkg`:
  - FSM state enum typedef (IDLE, RUN, DONE).
  - Default width constant (8).
  - Shared by later arithmetic blocks.
- Sub-module `my_full_adder`: outputs sum and carry, inputs a, b and cin. Built from two `my_half_adder` instances plus an OR of their carries. This block instantiates it once.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, `out_ready`=1 → `out_valid` exactly 8 cycles after accept; `sum`=0x10, `carry_out`=0, `overflow`=0.
- a=0xFF, b=0x01 → `sum`=0x00, `carry_out`=1, `overflow`=0. Then a=0x00, b=0x00 → `sum`=0x00, `carry_out`=0, proving the carry register was cleared at accept.
- Overflow build: a=0x80, b=0x80 → `sum`=0x00, `carry_out`=1, `overflow`=1. Then a=0x7F, b=0x01 → `sum`=0x80, `carry_out`=0, `overflow`=1.
- Backpressure: a=0x12, b=0x34, `out_ready`=0 for 5 cycles after `out_valid` → `sum`=0x46 stable, `in_ready`=0 throughout. Then `out_ready`=1 → IDLE and `in_ready`=1 next cycle. Also check that `in_valid` pulsed during RUN is ignored.
- Reset mid-op: accept a=0xAA, b=0x55, drop `rst_n` for 1 cycle after 3 RUN cycles → `out_valid`=0, `sum`=0, `in_ready`=1. Next operation a=0x01, b=0x02 → `sum`=0x03.
- Exhaustive sweep at WIDTH=4: all 256 (a, b) pairs back-to-back → `{carry_out, sum}` == a+b every time.
